// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and counter sizing helper.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count n values, never less than one so the counter always exists.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/digit_serial_adder_chunk_add.sv
// Combinational CHUNK-bit ripple slice: s = x + y + cin, carry out of the top bit on cout.
module chunk_add #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    localparam int unsigned SW = CHUNK + 1;

    assign {cout, s} = SW'(x) + SW'(y) + SW'(cin);

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first, with a registered ripple carry.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = clog2(NCHUNK);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("digit_serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_t                        state;
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q;
    logic [NCHUNK-1:0][CHUNK-1:0]  b_q;
    logic [NCHUNK-1:0][CHUNK-1:0]  sum_q;
    logic                          carry_q;
    logic [CW-1:0]                 cnt_q;

    logic [CHUNK-1:0]              a_c;
    logic [CHUNK-1:0]              b_c;
    logic [CHUNK-1:0]              s_c;
    logic                          cout_c;
    logic                          last_c;
    logic                          a_msb_c;
    logic                          b_msb_c;

    // Select the operand chunk addressed by the counter.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int unsigned j = 0; j < NCHUNK; j++) begin
            if (cnt_q == CW'(j)) begin
                a_c = a_q[j];
                b_c = b_q[j];
            end
        end
    end

    assign last_c  = (cnt_q == CW'(NCHUNK - 1));
    assign a_msb_c = a_q[NCHUNK-1][CHUNK-1];
    assign b_msb_c = b_q[NCHUNK-1][CHUNK-1];
    assign sum     = sum_q;

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .x    (a_c),
        .y    (b_c),
        .cin  (carry_q),
        .s    (s_c),
        .cout (cout_c)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_q     <= '0;
            cy        <= 1'b0;
            ovf       <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry_q  <= sub;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned j = 0; j < NCHUNK; j++) begin
                        if (cnt_q == CW'(j)) begin
                            sum_q[j] <= s_c;
                        end
                    end
                    carry_q <= cout_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_c) begin
                        cy        <= cout_c;
                        ovf       <= (a_msb_c == b_msb_c) && (s_c[CHUNK-1] != a_msb_c);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: 8-bit/2-bit and 3-bit/1-bit instances against an arithmetic model.
module tb_digit_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cy;
        logic       ovf;
        int         acc;
    } exp_t;

    logic       clk;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       rst8, iv8, ir8, sub8, ov8, or8, cy8, ovf8;
    logic [7:0] a8, b8, s8;
    logic       rst3, iv3, ir3, sub3, ov3, or3, cy3, ovf3;
    logic [2:0] a3, b3, s3;
    int         om8 = 2;
    int         om3 = 2;
    logic       vis8 = 1'b0;
    logic       vis3 = 1'b0;

    exp_t q8[$];
    exp_t q3[$];

    digit_serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cy(cy8), .ovf(ovf8)
    );

    digit_serial_adder #(.WIDTH(3), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .sub(sub3),
        .out_valid(ov3), .out_ready(or3), .sum(s3), .cy(cy3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true signed result.
    function automatic exp_t model(input int w, input int av, input int bv, input bit sb, input int acc);
        exp_t e;
        int   m    = (1 << w) - 1;
        int   half = 1 << (w - 1);
        int   ua   = av & m;
        int   ub   = bv & m;
        int   sa   = (ua >= half) ? ua - (1 << w) : ua;
        int   sbv  = (ub >= half) ? ub - (1 << w) : ub;
        int   r;
        if (sb) begin
            e.sum = 8'((ua - ub) & m);
            e.cy  = (ua >= ub);
            r     = sa - sbv;
        end else begin
            e.sum = 8'((ua + ub) & m);
            e.cy  = ((ua + ub) > m);
            r     = sa + sbv;
        end
        e.ovf = (r > half - 1) || (r < -half);
        e.acc = acc;
        return e;
    endfunction

    // Consumer ready generators: 0 random, 1 held low, 2 held high.
    always @(posedge clk) begin
        #1;
        or8 = (om8 == 2) ? 1'b1 : (om8 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        or3 = (om3 == 2) ? 1'b1 : (om3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitors: latency on first out_valid, result compare on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst8) begin
            if (ov8 && !vis8) begin
                chk("d8_pending", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) chk("d8_latency", cyc - q8[0].acc, 4);
            end
            if (ov8 && or8 && q8.size() != 0) begin
                e = q8.pop_front();
                chk("d8_result{sum,cy,ovf}", 32'({s8, cy8, ovf8}), 32'({e.sum, e.cy, e.ovf}));
            end
        end
        vis8 = ov8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst3) begin
            if (ov3 && !vis3) begin
                chk("d3_pending", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) chk("d3_latency", cyc - q3[0].acc, 3);
            end
            if (ov3 && or3 && q3.size() != 0) begin
                e = q3.pop_front();
                chk("d3_result{sum,cy,ovf}", 32'({s3, cy3, ovf3}), 32'({e.sum[2:0], e.cy, e.ovf}));
            end
        end
        vis3 = ov3;
    end

    task automatic drive8(input int av, input int bv, input bit sv);
        int n = 0;
        @(negedge clk);
        a8 = 8'(av); b8 = 8'(bv); sub8 = sv; iv8 = 1'b1;
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("d8_accept", 32'(ir8), 1);
        if (!ir8) begin
            iv8 = 1'b0;
            return;
        end
        q8.push_back(model(8, av, bv, sv, cyc + 1));
        @(posedge clk);
        #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic drive3(input int av, input int bv, input bit sv);
        int n = 0;
        @(negedge clk);
        a3 = 3'(av); b3 = 3'(bv); sub3 = sv; iv3 = 1'b1;
        while (!ir3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("d3_accept", 32'(ir3), 1);
        if (!ir3) begin
            iv3 = 1'b0;
            return;
        end
        q3.push_back(model(3, av, bv, sv, cyc + 1));
        @(posedge clk);
        #1;
        iv3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); sub3 = 1'($urandom);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(q8.size() + q3.size()), 0);
    endtask

    initial begin
        logic [7:0] hs;
        logic       hc, ho;
        int         n;

        rst8 = 1'b1; rst3 = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        iv3 = 1'b0; a3 = '0; b3 = '0; sub3 = 1'b0;
        or8 = 1'b0; or3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("d8_reset{ir,ov,sum,cy,ovf}", 32'({ir8, ov8, s8, cy8, ovf8}), 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
        chk("d3_reset{ir,ov,sum,cy,ovf}", 32'({ir3, ov3, s3, cy3, ovf3}), 32'({1'b1, 1'b0, 3'h0, 1'b0, 1'b0}));
        rst8 = 1'b0; rst3 = 1'b0;

        // Directed arithmetic corners
        drive8(8'h00, 8'h00, 1'b0);
        drive8(8'hFF, 8'h01, 1'b0);
        drive8(8'h7F, 8'h01, 1'b0);
        drive8(8'h05, 8'h07, 1'b1);
        drive8(8'h80, 8'h01, 1'b1);
        drive3(2, 3, 1'b0);
        drive3(7, 4, 1'b0);
        drive3(7, 6, 1'b0);
        drain("directed_drain");

        // Backpressure in DONE
        om8 = 1;
        drive8(8'h3C, 8'h15, 1'b0);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(ov8), 1);
        hs = s8; hc = cy8; ho = ovf8;
        chk("bp_sum", 32'(hs), 32'h51);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold{ov,ir,sum,cy,ovf}", 32'({ov8, ir8, s8, cy8, ovf8}), 32'({1'b1, 1'b0, hs, hc, ho}));
        end
        iv8 = 1'b0;
        om8 = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release{ov,ir}", 32'({ov8, ir8}), 32'({1'b0, 1'b1}));
        drain("bp_drain");

        // Reset during the second RUN cycle
        drive8(8'h55, 8'h66, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        void'(q8.pop_back());
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrun_reset{ov,ir,sum}", 32'({ov8, ir8, s8}), 32'({1'b0, 1'b1, 8'h00}));
        drive8(8'h10, 8'h20, 1'b0);
        drain("reset_drain");

        // Randomised traffic with random consumer stalls
        om8 = 0; om3 = 0;
        for (int i = 0; i < 150; i++) begin
            drive8($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            drive3($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
